// File: rtl/vga_fetch_sched.sv
// vga_fetch_sched: burst-read scheduler that keeps the display pixel FIFO
// fed from the framebuffer. A frame_start pulse flushes the FIFO and
// realigns the read pointer to FB_BASE. While the FIFO has room for a full
// burst, a fixed-length read is requested. Returned beats are forwarded to
// the FIFO write port.
//
// Ports:
//   pixel_clk, pixel_rst_n    clock, synchronous active-low reset
//   enable                    allow new bursts to be issued
//   frame_start               one-cycle pulse at start of frame
//   fifo_level                current pixel FIFO occupancy
//   fifo_wr, fifo_wdata       FIFO write strobe and data (registered)
//   fifo_flush                one-cycle FIFO clear
//   mem_cmd_valid/ready       burst read request handshake
//   mem_addr, mem_burst       burst start byte address and length
//   mem_rvalid, mem_rdata     read data beats
//   busy                      a burst is outstanding (CMD or DATA)
//   frame_done                pulse after the last word of a frame
module vga_fetch_sched #(
   parameter int unsigned HDISP      = 800,
   parameter int unsigned VDISP      = 480,
   parameter int unsigned BURST      = 16,
   parameter int unsigned FIFO_DEPTH = 256,
   parameter int unsigned ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
   input  logic                            pixel_clk,
   input  logic                            pixel_rst_n,
   input  logic                            enable,
   input  logic                            frame_start,
   input  logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            fifo_wr,
   output logic [31:0]                     fifo_wdata,
   output logic                            fifo_flush,
   output logic                            mem_cmd_valid,
   input  logic                            mem_cmd_ready,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [$clog2(BURST):0]          mem_burst,
   input  logic                            mem_rvalid,
   input  logic [31:0]                     mem_rdata,
   output logic                            busy,
   output logic                            frame_done
);

   localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BEAT_W = $clog2(BURST) + 1;
   localparam int unsigned TOTAL  = HDISP * VDISP;
   localparam int unsigned WORD_W = $clog2(TOTAL + 1);

   // Room for a full burst: FIFO_DEPTH - fifo_level >= BURST.
   localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(FIFO_DEPTH - BURST);
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(TOTAL - BURST);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4 * BURST);

   typedef enum logic [2:0] {StIdle, StFlush, StWaitSpace, StCmd, StData} state_t;

   state_t              state, state_next;
   logic [WORD_W-1:0]   word_cnt;
   logic [BEAT_W-1:0]   beat_cnt;
   logic                discard;
   logic                last_beat;
   logic                drop;

   assign mem_burst = BEAT_W'(BURST);
   assign last_beat = (state == StData) && mem_rvalid && (beat_cnt == BEAT_W'(1));
   // A frame_start arriving with a beat drops that beat as well.
   assign drop      = discard || frame_start;

   always_comb begin
      state_next = state;
      unique case (state)
         StIdle: begin
            if (frame_start) state_next = StFlush;
         end
         StFlush: begin
            state_next = frame_start ? StFlush : StWaitSpace;
         end
         StWaitSpace: begin
            // Hold off while the last beat's write is still in flight so
            // fifo_level already accounts for it.
            if (frame_start) begin
               state_next = StFlush;
            end else if (enable && !fifo_wr && (fifo_level <= LVL_MAX)) begin
               state_next = StCmd;
            end
         end
         StCmd: begin
            if (mem_cmd_ready) state_next = StData;
         end
         StData: begin
            if (last_beat) begin
               if (drop) begin
                  state_next = StFlush;
               end else if (word_cnt == LAST_WORD) begin
                  state_next = StIdle;
               end else begin
                  state_next = StWaitSpace;
               end
            end
         end
         default: state_next = StIdle;
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (!pixel_rst_n) begin
         state         <= StIdle;
         mem_cmd_valid <= 1'b0;
         mem_addr      <= FB_BASE;
         fifo_wr       <= 1'b0;
         fifo_wdata    <= '0;
         fifo_flush    <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         word_cnt      <= '0;
         beat_cnt      <= '0;
         discard       <= 1'b0;
      end else begin
         state         <= state_next;
         // Outputs decoded from the next state so they line up with it.
         mem_cmd_valid <= (state_next == StCmd);
         busy          <= (state_next == StCmd) || (state_next == StData);
         fifo_flush    <= (state_next == StFlush);
         fifo_wr       <= 1'b0;
         frame_done    <= 1'b0;

         if ((state == StCmd) && mem_cmd_ready) begin
            beat_cnt <= BEAT_W'(BURST);
         end

         if (((state == StCmd) || (state == StData)) && frame_start) begin
            discard <= 1'b1;
         end

         if ((state == StData) && mem_rvalid) begin
            fifo_wdata <= mem_rdata;
            fifo_wr    <= !drop;
            beat_cnt   <= beat_cnt - BEAT_W'(1);
         end

         if (last_beat) begin
            mem_addr <= mem_addr + ADDR_STEP;
            word_cnt <= word_cnt + WORD_W'(BURST);
            if (!drop && (word_cnt == LAST_WORD)) frame_done <= 1'b1;
         end

         // Entering FLUSH realigns to the frame start; overrides the above.
         if (state_next == StFlush) begin
            mem_addr <= FB_BASE;
            word_cnt <= '0;
            discard  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_fetch_sched.sv
module tb_vga_fetch_sched;

   localparam int unsigned HDISP      = 8;
   localparam int unsigned VDISP      = 2;
   localparam int unsigned BURST      = 4;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BEAT_W     = $clog2(BURST) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              frame_start = 1'b0;
   logic [LVL_W-1:0]  level = '0;
   logic              ready = 1'b0;
   logic              auto_mem = 1'b1;
   logic              noise = 1'b0;
   logic              resp_rvalid = 1'b0;
   logic [31:0]       resp_rdata = '0;
   logic              man_rvalid = 1'b0;
   logic [31:0]       man_rdata = '0;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   logic              fifo_wr, fifo_flush, mem_cmd_valid, busy, frame_done;
   logic [31:0]       fifo_wdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [BEAT_W-1:0] mem_burst;

   assign mem_rvalid = auto_mem ? resp_rvalid : man_rvalid;
   assign mem_rdata  = auto_mem ? resp_rdata : man_rdata;

   vga_fetch_sched #(
      .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH),
      .ADDR_W(ADDR_W), .FB_BASE(32'h0)
   ) dut (
      .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(enable), .frame_start(frame_start),
      .fifo_level(level), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
      .fifo_flush(fifo_flush), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(ready),
      .mem_addr(mem_addr), .mem_burst(mem_burst), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0, cmd_cnt = 0, flush_cnt = 0, done_cnt = 0;
   logic [31:0]       wr_q[$];
   logic [ADDR_W-1:0] addr_q[$];

   // Memory model: word at byte address A holds A>>2. Every beat it returns
   // is expected at the FIFO write port, in order.
   int          pend = 0;
   logic [31:0] rbase = '0;
   logic [31:0] rk = '0;
   logic [31:0] cyc = '0;
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         pend = 0;
         resp_rvalid = 1'b0;
      end else if (pend > 0) begin
         resp_rvalid = 1'b1;
         resp_rdata = rbase + rk;
         wr_q.push_back(rbase + rk);
         rk = rk + 1;
         pend = pend - 1;
      end else begin
         // Junk beats outside a burst must be ignored by the DUT.
         resp_rvalid = noise;
         resp_rdata = {16'hDEAD, cyc[15:0]};
      end
      if (auto_mem && rst_n && mem_cmd_valid === 1'b1 && ready) begin
         pend = BURST;
         rbase = mem_addr >> 2;
         rk = '0;
      end
   end

   // Scoreboard side: pop expected writes and command addresses as they occur.
   always @(negedge clk) begin
      logic [31:0]       exp_w;
      logic [ADDR_W-1:0] exp_a;
      if (fifo_wr === 1'b1) begin
         wr_cnt++;
         total++;
         if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL wr_unexpected: got wdata=%h, no write expected", fifo_wdata);
         end else begin
            exp_w = wr_q.pop_front();
            if (fifo_wdata !== exp_w) begin
               bad++;
               $display("FAIL wdata: got %h, expected %h", fifo_wdata, exp_w);
            end
         end
      end
      if (mem_cmd_valid === 1'b1 && ready) begin
         cmd_cnt++;
         total++;
         if (addr_q.size() == 0) begin
            bad++;
            $display("FAIL cmd_unexpected: got addr=%h, no command expected", mem_addr);
         end else begin
            exp_a = addr_q.pop_front();
            if (mem_addr !== exp_a || mem_burst !== BEAT_W'(BURST)) begin
               bad++;
               $display("FAIL cmd_addr: got addr=%h burst=%0d, expected addr=%h burst=%0d",
                        mem_addr, mem_burst, exp_a, BURST);
            end
         end
      end
      if (fifo_flush === 1'b1) flush_cnt++;
      if (frame_done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({mem_cmd_valid, fifo_wr, fifo_flush, busy, frame_done} !== 5'b0 ||
          mem_addr !== 32'h0 || fifo_wdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_values: got v=%b wr=%b fl=%b busy=%b done=%b addr=%h wd=%h, expected all 0",
                  mem_cmd_valid, fifo_wr, fifo_flush, busy, frame_done, mem_addr, fifo_wdata);
      end
      rst_n = 1'b1;
      enable = 1'b1;
      ready = 1'b1;
      level = '0;
      repeat (4) tick();
      total++;
      if (mem_cmd_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_wait: got valid=%b busy=%b, expected 0 0", mem_cmd_valid, busy);
      end
   endtask

   task automatic test_full_frame();
      int w0 = wr_cnt, c0 = cmd_cnt, f0 = flush_cnt, d0 = done_cnt;
      noise = 1'b1;
      for (int i = 0; i < 4; i++) addr_q.push_back(32'(i * 16));
      pulse_frame_start();
      total++;
      if (fifo_flush !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL flush_start: got flush=%b busy=%b, expected 1 0", fifo_flush, busy);
      end
      tick();
      total++;
      if (fifo_flush !== 1'b0) begin
         bad++;
         $display("FAIL flush_width: got flush=%b, expected 0", fifo_flush);
      end
      for (int i = 0; i < 100 && done_cnt < d0 + 1; i++) tick();
      repeat (3) tick();
      total++;
      if (done_cnt - d0 != 1 || wr_cnt - w0 != 16 || cmd_cnt - c0 != 4 || flush_cnt - f0 != 1) begin
         bad++;
         $display("FAIL frame_counts: got done=%0d wr=%0d cmd=%0d flush=%0d, expected 1 16 4 1",
                  done_cnt - d0, wr_cnt - w0, cmd_cnt - c0, flush_cnt - f0);
      end
      total++;
      if (busy !== 1'b0 || mem_cmd_valid !== 1'b0 || addr_q.size() != 0 || wr_q.size() != 0) begin
         bad++;
         $display("FAIL frame_idle: got busy=%b valid=%b addr_left=%0d wr_left=%0d, expected 0 0 0 0",
                  busy, mem_cmd_valid, addr_q.size(), wr_q.size());
      end
   endtask

   task automatic test_level_gate();
      int vcnt = 0;
      int w0 = wr_cnt;
      level = LVL_W'(5);
      addr_q.push_back(32'h0);
      pulse_frame_start();
      repeat (8) begin
         tick();
         if (mem_cmd_valid === 1'b1) vcnt++;
      end
      total++;
      if (vcnt != 0) begin
         bad++;
         $display("FAIL level5_gate: got %0d valid cycles, expected 0", vcnt);
      end
      level = LVL_W'(4);
      tick();
      total++;
      if (mem_cmd_valid !== 1'b1 || mem_addr !== 32'h0) begin
         bad++;
         $display("FAIL level4_cmd: got valid=%b addr=%h, expected 1 00000000", mem_cmd_valid, mem_addr);
      end
      level = LVL_W'(8);
      for (int i = 0; i < 20 && wr_cnt < w0 + 4; i++) tick();
      repeat (3) tick();
      total++;
      if (wr_cnt - w0 != 4 || mem_cmd_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL level_park: got wr=%0d valid=%b busy=%b, expected 4 0 0",
                  wr_cnt - w0, mem_cmd_valid, busy);
      end
   endtask

   task automatic test_frame_restart();
      int w0 = wr_cnt, c0 = cmd_cnt;
      auto_mem = 1'b0;
      man_rvalid = 1'b0;
      addr_q.push_back(32'h10);
      level = '0;
      tick();
      total++;
      if (mem_cmd_valid !== 1'b1 || mem_addr !== 32'h10) begin
         bad++;
         $display("FAIL restart_cmd: got valid=%b addr=%h, expected 1 00000010", mem_cmd_valid, mem_addr);
      end
      level = LVL_W'(8);
      tick();
      man_rvalid = 1'b1;
      man_rdata = 32'd4;
      wr_q.push_back(32'd4);
      tick();
      man_rdata = 32'd5;
      wr_q.push_back(32'd5);
      tick();
      man_rvalid = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      total++;
      if (busy !== 1'b1 || fifo_flush !== 1'b0) begin
         bad++;
         $display("FAIL restart_drain: got busy=%b flush=%b, expected 1 0", busy, fifo_flush);
      end
      // Beats 3 and 4 must be dropped: nothing pushed for them.
      man_rvalid = 1'b1;
      man_rdata = 32'd6;
      tick();
      man_rdata = 32'd7;
      tick();
      man_rvalid = 1'b0;
      total++;
      if (fifo_flush !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL restart_flush: got flush=%b busy=%b, expected 1 0", fifo_flush, busy);
      end
      addr_q.push_back(32'h0);
      level = '0;
      auto_mem = 1'b1;
      tick();
      tick();
      total++;
      if (wr_cnt - w0 != 2) begin
         bad++;
         $display("FAIL restart_writes: got %0d writes, expected 2", wr_cnt - w0);
      end
      for (int i = 0; i < 20 && cmd_cnt < c0 + 2; i++) tick();
      level = LVL_W'(8);
      for (int i = 0; i < 20 && wr_cnt < w0 + 6; i++) tick();
      repeat (3) tick();
      total++;
      if (cmd_cnt - c0 != 2 || wr_cnt - w0 != 6 || addr_q.size() != 0) begin
         bad++;
         $display("FAIL restart_realign: got cmd=%0d wr=%0d addr_left=%0d, expected 2 6 0",
                  cmd_cnt - c0, wr_cnt - w0, addr_q.size());
      end
   endtask

   task automatic test_ready_delay();
      int w0 = wr_cnt;
      addr_q.push_back(32'h10);
      ready = 1'b0;
      level = '0;
      tick();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (mem_cmd_valid !== 1'b1 || mem_addr !== 32'h10) begin
            bad++;
            $display("FAIL ready_hold%0d: got valid=%b addr=%h, expected 1 00000010",
                     k, mem_cmd_valid, mem_addr);
         end
         if (k == 3) begin
            ready = 1'b1;
            level = LVL_W'(8);
         end
         tick();
      end
      total++;
      if (mem_cmd_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL ready_accept: got valid=%b busy=%b, expected 0 1", mem_cmd_valid, busy);
      end
      for (int i = 0; i < 20 && wr_cnt < w0 + 4; i++) tick();
      tick();
      total++;
      if (wr_cnt - w0 != 4 || addr_q.size() != 0) begin
         bad++;
         $display("FAIL ready_burst: got wr=%0d addr_left=%0d, expected 4 0", wr_cnt - w0, addr_q.size());
      end
   endtask

   task automatic test_enable_drop();
      int vcnt = 0;
      int w0 = wr_cnt, c0 = cmd_cnt, d0 = done_cnt;
      addr_q.push_back(32'h20);
      level = '0;
      tick();
      tick();
      tick();
      enable = 1'b0;
      for (int i = 0; i < 20 && wr_cnt < w0 + 4; i++) tick();
      repeat (10) begin
         tick();
         if (mem_cmd_valid === 1'b1) vcnt++;
      end
      total++;
      if (vcnt != 0 || wr_cnt - w0 != 4 || cmd_cnt - c0 != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL enable_off: got valid_cycles=%0d wr=%0d cmd=%0d busy=%b, expected 0 4 1 0",
                  vcnt, wr_cnt - w0, cmd_cnt - c0, busy);
      end
      addr_q.push_back(32'h30);
      enable = 1'b1;
      for (int i = 0; i < 30 && done_cnt < d0 + 1; i++) tick();
      tick();
      total++;
      if (done_cnt - d0 != 1 || cmd_cnt - c0 != 2 || wr_cnt - w0 != 8 || addr_q.size() != 0) begin
         bad++;
         $display("FAIL enable_resume: got done=%0d cmd=%0d wr=%0d addr_left=%0d, expected 1 2 8 0",
                  done_cnt - d0, cmd_cnt - c0, wr_cnt - w0, addr_q.size());
      end
   endtask

   task automatic test_reset_mid_data();
      int w0 = wr_cnt, d0 = done_cnt;
      noise = 1'b0;
      level = '0;
      for (int i = 0; i < 4; i++) addr_q.push_back(32'(i * 16));
      pulse_frame_start();
      for (int i = 0; i < 60 && wr_cnt < w0 + 13; i++) tick();
      rst_n = 1'b0;
      tick();
      total++;
      if ({mem_cmd_valid, fifo_wr, fifo_flush, busy, frame_done} !== 5'b0 ||
          mem_addr !== 32'h0 || fifo_wdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_mid: got v=%b wr=%b fl=%b busy=%b done=%b addr=%h wd=%h, expected all 0",
                  mem_cmd_valid, fifo_wr, fifo_flush, busy, frame_done, mem_addr, fifo_wdata);
      end
      rst_n = 1'b1;
      repeat (10) tick();
      total++;
      if (done_cnt != d0 || mem_cmd_valid !== 1'b0 || busy !== 1'b0 ||
          addr_q.size() != 0 || wr_q.size() != 0 || wr_cnt - w0 < 13) begin
         bad++;
         $display("FAIL reset_after: got done=%0d valid=%b busy=%b addr_left=%0d wr_left=%0d wr=%0d, expected 0 0 0 0 0 >=13",
                  done_cnt - d0, mem_cmd_valid, busy, addr_q.size(), wr_q.size(), wr_cnt - w0);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_level_gate();
      test_frame_restart();
      test_ready_delay();
      test_enable_drop();
      test_reset_mid_data();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
